demod_iq_acc: RTL

- Digital I/Q demodulator datapath directly downstream of the demodulation sampling controller.
- Multiplies each gated ADC sample by internal cosine/sine reference tables and accumulates in-phase and quadrature sums.
- On the controller's ready strobe, captures both sums into a held result register, handed to the readout path with a valid/ready handshake.
- Sits between the sampling controller and the per-channel result FIFO/readout mux.

---
 rtl/demod_pkg.sv | 27 ++
 rtl/demod_iq_acc_if.sv | 39 +++
 rtl/demod_ref_lut.sv | 42 ++++
 rtl/demod_iq_acc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared defaults, FSM state type and reference-table generator for the I/Q demodulator.
package demod_pkg;

  localparam int  PHASE_STEPS_DEF = 20;
  localparam int  REF_W_DEF       = 12;
  localparam int  ACC_W_DEF       = 40;
  localparam int  DATA_W          = 14;
  localparam real TWO_PI          = 6.283185307179586;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rounded (half away from zero) A*cos or A*sin of 2*pi*k/steps, A = 2^(ref_w-1)-1.
  function automatic int ref_entry(input int k, input int steps, input int ref_w, input bit is_sin);
    real ang;
    real amp;
    real v;
    ang = TWO_PI * real'(k) / real'(steps);
    amp = real'((1 << (ref_w - 1)) - 1);
    v   = is_sin ? amp * $sin(ang) : amp * $cos(ang);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

endpackage

// File: rtl/demod_iq_acc_if.sv
// Controller-side inputs and readout handshake of demod_iq_acc; slave = datapath, master = driver.
// DEMOD_OTR_CNT_EN adds the OtrCnt result field.
interface demod_iq_acc_if
  import demod_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);
  logic                     Aclr;
  logic                     ClkMultEn;
  logic signed [DATA_W-1:0] DataIn;
  logic                     OverFlow;
  logic                     DemodRdy;
  logic                     ResReady;
  logic                     ResValid;
  logic signed [ACC_W-1:0]  IOut;
  logic signed [ACC_W-1:0]  QOut;
  logic                     ResSat;
  logic                     ResDrop;
`ifdef DEMOD_OTR_CNT_EN
  logic [7:0]               OtrCnt;
`endif

  modport master (
    output Aclr, ClkMultEn, DataIn, OverFlow, DemodRdy, ResReady,
    input  ResValid, IOut, QOut, ResSat, ResDrop
`ifdef DEMOD_OTR_CNT_EN
    , OtrCnt
`endif
  );

  modport slave (
    input  Aclr, ClkMultEn, DataIn, OverFlow, DemodRdy, ResReady,
    output ResValid, IOut, QOut, ResSat, ResDrop
`ifdef DEMOD_OTR_CNT_EN
    , OtrCnt
`endif
  );

endinterface

// File: rtl/demod_ref_lut.sv
// Phase counter with cos/sin reference tables built at elaboration; advances while en, zeroed by clr.
module demod_ref_lut
  import demod_pkg::*;
#(
  parameter int PHASE_STEPS = PHASE_STEPS_DEF,
  parameter int REF_W       = REF_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  output logic signed [REF_W-1:0] cos_val,
  output logic signed [REF_W-1:0] sin_val
);
  localparam int PH_W = $clog2(PHASE_STEPS);

  logic [PH_W-1:0]         phase;
  logic signed [REF_W-1:0] cos_tab [PHASE_STEPS];
  logic signed [REF_W-1:0] sin_tab [PHASE_STEPS];

  // NOTE: the tables are elaboration-time constants, so they carry no reset; only phase does.
  for (genvar k = 0; k < PHASE_STEPS; k++) begin : g_tab
    localparam int C = ref_entry(k, PHASE_STEPS, REF_W, 1'b0);
    localparam int S = ref_entry(k, PHASE_STEPS, REF_W, 1'b1);
    assign cos_tab[k] = REF_W'(C);
    assign sin_tab[k] = REF_W'(S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == PH_W'(PHASE_STEPS - 1)) ? '0 : phase + 1'b1;
    end
  end

  assign cos_val = cos_tab[phase];
  assign sin_val = sin_tab[phase];

endmodule

// File: rtl/demod_iq_acc.sv
// I/Q demodulator datapath: 3-stage multiply/accumulate against cos/sin references, captured
// into a held result with valid/ready handoff. DEMOD_OTR_CNT_EN adds an out-of-range counter.
module demod_iq_acc
  import demod_pkg::*;
#(
  parameter int PHASE_STEPS = PHASE_STEPS_DEF,
  parameter int REF_W       = REF_W_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  demod_iq_acc_if.slave bus
);
  localparam int PROD_W = DATA_W + REF_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  state_t                   state, state_nxt;
  logic                     en, capture;
  logic                     rdy_q1, rdy_q2, rdy_rise;
  logic signed [REF_W-1:0]  cos_val, sin_val;
  logic signed [DATA_W-1:0] s0_data;
  logic signed [REF_W-1:0]  s0_cos, s0_sin;
  logic signed [PROD_W-1:0] s1_prod_i, s1_prod_q;
  logic signed [SUM_W-1:0]  sum_i, sum_q;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic                     sat_hit, sat_flag;
  logic                     res_valid, res_sat, res_drop;
  logic signed [ACC_W-1:0]  res_i, res_q;

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [SUM_W-1:0] s);
    if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return s[ACC_W-1:0];
  endfunction

  // Pipeline and phase are frozen outside an active, enabled run.
  assign en = bus.ClkMultEn && !bus.Aclr && (state != DONE);

  demod_ref_lut #(
    .PHASE_STEPS (PHASE_STEPS),
    .REF_W       (REF_W)
  ) u_lut (
    .clk     (CLK),
    .rst     (RST),
    .en      (en),
    .clr     (bus.Aclr),
    .cos_val (cos_val),
    .sin_val (sin_val)
  );

  // DemodRdy edge is taken between two registered copies, giving the two-edge capture latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy_q1 <= 1'b0;
      rdy_q2 <= 1'b0;
    end else begin
      rdy_q1 <= bus.DemodRdy;
      rdy_q2 <= rdy_q1;
    end
  end
  assign rdy_rise = rdy_q1 && !rdy_q2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults come first so every path assigns state_nxt and capture -- no latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (bus.Aclr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.ClkMultEn) state_nxt = ACC;
        ACC: begin
          if (rdy_rise) begin
            state_nxt = DONE;
            capture   = 1'b1;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    sum_i   = SUM_W'(acc_i) + SUM_W'(s1_prod_i);
    sum_q   = SUM_W'(acc_q) + SUM_W'(s1_prod_q);
    sat_hit = (sum_i > ACC_MAX) || (sum_i < ACC_MIN) || (sum_q > ACC_MAX) || (sum_q < ACC_MIN);
  end

  // NOTE: non-blocking assignments so each stage loads the previous stage's pre-edge value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_data   <= '0;
      s0_cos    <= '0;
      s0_sin    <= '0;
      s1_prod_i <= '0;
      s1_prod_q <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sat_flag  <= 1'b0;
    end else if (bus.Aclr) begin
      s0_data   <= '0;
      s0_cos    <= '0;
      s0_sin    <= '0;
      s1_prod_i <= '0;
      s1_prod_q <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sat_flag  <= 1'b0;
    end else if (en) begin
      s0_data   <= bus.DataIn;
      s0_cos    <= cos_val;
      s0_sin    <= sin_val;
      s1_prod_i <= s0_data * s0_cos;
      s1_prod_q <= s0_data * s0_sin;
      acc_i     <= clamp(sum_i);
      acc_q     <= clamp(sum_q);
      if (sat_hit) sat_flag <= 1'b1;
    end
  end

  // Result register is untouched by Aclr so an unread result survives a run restart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_i     <= '0;
      res_q     <= '0;
      res_sat   <= 1'b0;
      res_drop  <= 1'b0;
    end else begin
      res_drop <= 1'b0;
      if (capture) begin
        res_i     <= acc_i;
        res_q     <= acc_q;
        res_sat   <= sat_flag;
        res_valid <= 1'b1;
        res_drop  <= res_valid && !bus.ResReady;
      end else if (res_valid && bus.ResReady) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.ResValid = res_valid;
  assign bus.IOut     = res_i;
  assign bus.QOut     = res_q;
  assign bus.ResSat   = res_sat;
  assign bus.ResDrop  = res_drop;

`ifdef DEMOD_OTR_CNT_EN
  logic [7:0] otr_cnt, res_otr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      otr_cnt <= '0;
    end else if (bus.Aclr) begin
      otr_cnt <= '0;
    end else if (en && bus.OverFlow && (otr_cnt != 8'hFF)) begin
      otr_cnt <= otr_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          res_otr <= '0;
    else if (capture) res_otr <= otr_cnt;
  end

  assign bus.OtrCnt = res_otr;
`else
  logic unused_ovf;
  assign unused_ovf = bus.OverFlow;
`endif

endmodule
